dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's load/store interface, replacing the zero-wait combinational data memory with a valid/ready request/response protocol.
- Accepts one load or store at a time and inserts a configurable number of wait states.
- Performs RV32I byte/halfword/word lane handling, including load sign/zero extension, and flags illegal accesses.
- Sits between the core's memory stage and the on-chip data SRAM array, which it holds internally.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request-response bus between the core memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one RV32I load/store at a time over valid/ready,
// with programmable wait states, lane handling and illegal-access flagging.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        l_we;
  logic [2:0]  l_f;
  logic [31:0] l_addr, l_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit;
  logic          op_we;
  logic [2:0]    op_f;
  logic [31:0]   op_addr, op_wdata;
  logic [AW-1:0] idx;
  logic [31:0]   word, shifted, load_data, wr_data;
  logic [15:0]   half;
  logic [3:0]    be;
  logic          err;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign accept        = bus.req_valid && bus.req_ready;

  // With zero wait states the commit happens on the accept edge itself, so the
  // operands come straight off the bus rather than from the latched copies.
  always_comb begin
    if (state == IDLE) begin
      op_we    = bus.req_we;
      op_f     = bus.req_funct3;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end else begin
      op_we    = l_we;
      op_f     = l_f;
      op_addr  = l_addr;
      op_wdata = l_wdata;
    end
  end

  always_comb begin
    if (WAIT_CYCLES == 0) commit = accept;
    else                  commit = (state == WAIT) && (cnt == 4'd1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign idx     = op_addr[AW+1:2];
  assign word    = mem[idx];
  assign shifted = word >> {op_addr[1:0], 3'b000};
  assign half    = op_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    err = ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS))
        || (op_f == 3'd3) || (op_f == 3'd6) || (op_f == 3'd7)
        || (op_we && op_f[2])
        || ((op_f[1:0] == 2'd1) && op_addr[0])
        || ((op_f[1:0] == 2'd2) && (op_addr[1:0] != 2'd0));
  end

  always_comb begin
    load_data = '0;
    if (!err && !op_we) begin
      case (op_f)
        3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
        3'd1:    load_data = {{16{half[15]}}, half};
        3'd2:    load_data = word;
        3'd4:    load_data = {24'd0, shifted[7:0]};
        3'd5:    load_data = {16'd0, half};
        default: load_data = '0;
      endcase
    end
  end

  // Store data is replicated across lanes; the byte enables pick the target.
  always_comb begin
    case (op_f[1:0])
      2'd0: begin
        be      = 4'b0001 << op_addr[1:0];
        wr_data = {4{op_wdata[7:0]}};
      end
      2'd1: begin
        be      = op_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{op_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = op_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      l_we          <= 1'b0;
      l_f           <= '0;
      l_addr        <= '0;
      l_wdata       <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        l_we    <= bus.req_we;
        l_f     <= bus.req_funct3;
        l_addr  <= bus.req_addr;
        l_wdata <= bus.req_wdata;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        bus.rsp_rdata <= load_data;
        bus.rsp_err   <= err;
      end else if ((state == RESP) && bus.rsp_ready) begin
        bus.rsp_rdata <= '0;
        bus.rsp_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && !rst && op_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (wait states 1/0/3), directed table,
// hand-written reset sequences and random traffic against a byte-array model.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        r_req_ready, r_rsp_valid, r_rsp_err;
  logic [31:0] r_rsp_rdata;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mdl [3][1024];

  always #5 clk = ~clk;

  dmem_responder_if b0 ();
  dmem_responder_if b1 ();
  dmem_responder_if b2 ();

  assign b0.req_valid = req_valid && (sel == 0);
  assign b1.req_valid = req_valid && (sel == 1);
  assign b2.req_valid = req_valid && (sel == 2);
  assign b0.rsp_ready = rsp_ready && (sel == 0);
  assign b1.rsp_ready = rsp_ready && (sel == 1);
  assign b2.rsp_ready = rsp_ready && (sel == 2);
  assign b0.req_we = req_we;         assign b1.req_we = req_we;         assign b2.req_we = req_we;
  assign b0.req_funct3 = req_funct3; assign b1.req_funct3 = req_funct3; assign b2.req_funct3 = req_funct3;
  assign b0.req_addr = req_addr;     assign b1.req_addr = req_addr;     assign b2.req_addr = req_addr;
  assign b0.req_wdata = req_wdata;   assign b1.req_wdata = req_wdata;   assign b2.req_wdata = req_wdata;

  assign r_req_ready = (sel == 0) ? b0.req_ready : (sel == 1) ? b1.req_ready : b2.req_ready;
  assign r_rsp_valid = (sel == 0) ? b0.rsp_valid : (sel == 1) ? b1.rsp_valid : b2.rsp_valid;
  assign r_rsp_err   = (sel == 0) ? b0.rsp_err   : (sel == 1) ? b1.rsp_err   : b2.rsp_err;
  assign r_rsp_rdata = (sel == 0) ? b0.rsp_rdata : (sel == 1) ? b1.rsp_rdata : b2.rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  dmem_responder #(.DEPTH_WORDS(16),  .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  dmem_responder #(.DEPTH_WORDS(16),  .WAIT_CYCLES(3)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    bit        we;
    bit [2:0]  f;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        hold;
    bit        err;
    bit [31:0] rdata;
  } vec_t;
  vec_t tbl[$];

  function automatic int depth_of(int d);
    return (d == 0) ? 256 : 16;
  endfunction

  function automatic int wait_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %h expected %h at %0t", name, sel, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory, size/alignment rules, arithmetic extension.
  task automatic ref_op(input int d, input bit we, input bit [2:0] f, input bit [31:0] a,
                        input bit [31:0] wd, output bit err, output bit [31:0] rd);
    int size;
    longint v;
    size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    err  = ((a / 4) >= 32'(depth_of(d))) || (f == 3) || (f == 6) || (f == 7)
        || (we && (f == 4 || f == 5)) || ((a % size) != 0);
    rd = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (longint'(mdl[d][int'(a) + i]) << (8*i));
        if (f < 4 && ((v >> (8*size - 1)) & 1) == 1) v = v - (longint'(1) << (8*size));
        rd = 32'(v);
      end
    end
  endtask

  // Called #1 after a rising edge with the selected DUT expected idle.
  task automatic txn(input bit we, input bit [2:0] f, input bit [31:0] a, input bit [31:0] wd,
                     input int hold, output bit err, output bit [31:0] rd);
    int n;
    n = 0;
    while (r_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_idle", 32'(r_req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (r_rsp_valid !== 1'b1 && n < 20) begin
      chk("req_ready_busy", 32'(r_req_ready), 32'd0);
      rsp_ready = 1'($urandom);
      @(posedge clk); #1; n++;
    end
    rsp_ready = 1'b0;
    chk("latency", 32'(n), 32'(wait_of(sel)));
    err = r_rsp_err;
    rd  = r_rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(r_rsp_valid), 32'd1);
      chk("hold_rdata", r_rsp_rdata, rd);
      chk("hold_err", 32'(r_rsp_err), 32'(err));
      chk("hold_req_ready", 32'(r_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("done_valid", 32'(r_rsp_valid), 32'd0);
    chk("done_req_ready", 32'(r_req_ready), 32'd1);
    chk("done_rdata", r_rsp_rdata, 32'd0);
  endtask

  task automatic model_txn(input bit we, input bit [2:0] f, input bit [31:0] a,
                           input bit [31:0] wd, input int hold);
    bit e_err, a_err;
    bit [31:0] e_rd, a_rd;
    ref_op(sel, we, f, a, wd, e_err, e_rd);
    txn(we, f, a, wd, hold, a_err, a_rd);
    chk("err", 32'(a_err), 32'(e_err));
    chk("rdata", a_rd, e_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit e_err, a_err;
    bit [31:0] e_rd, a_rd;
    bit [2:0] fsel [13];
    fsel = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    tbl.push_back('{1'b1, 3'd2, 32'h000, 32'h01020304, 0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'd2, 32'h010, 32'h0,        5, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b1, 3'd0, 32'h013, 32'h00000080, 0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'd0, 32'h013, 32'h0,        0, 1'b0, 32'hFFFFFF80});
    tbl.push_back('{1'b0, 3'd4, 32'h013, 32'h0,        0, 1'b0, 32'h00000080});
    tbl.push_back('{1'b0, 3'd2, 32'h010, 32'h0,        0, 1'b0, 32'h80ADBEEF});
    tbl.push_back('{1'b1, 3'd1, 32'h012, 32'h00001234, 0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'd5, 32'h012, 32'h0,        0, 1'b0, 32'h00001234});
    tbl.push_back('{1'b0, 3'd2, 32'h011, 32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 3'd1, 32'h013, 32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 3'd3, 32'h010, 32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 3'd0, 32'h400, 32'h000000FF, 2, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 3'd1, 32'h011, 32'h0000FFFF, 0, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 3'd5, 32'h010, 32'hFFFFFFFF, 0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 3'd2, 32'h010, 32'h0,        0, 1'b0, 32'h1234BEEF});
    tbl.push_back('{1'b0, 3'd2, 32'h000, 32'h0,        0, 1'b0, 32'h01020304});
    tbl.push_back('{1'b1, 3'd2, 32'h3FC, 32'hA5A55A5A, 0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'd1, 32'h3FE, 32'h0,        0, 1'b0, 32'hFFFFA5A5});
    tbl.push_back('{1'b0, 3'd0, 32'h3FD, 32'h0,        0, 1'b0, 32'h0000005A});
    tbl.push_back('{1'b0, 3'd5, 32'h3FC, 32'h0,        0, 1'b0, 32'h00005A5A});
    tbl.push_back('{1'b0, 3'd2, 32'h400, 32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 3'd6, 32'h010, 32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 3'd0, 32'h012, 32'h0,        0, 1'b0, 32'h00000034});
    tbl.push_back('{1'b0, 3'd1, 32'h010, 32'h0,        0, 1'b0, 32'hFFFFBEEF});

    // Reset held from time zero, then released.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(r_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(r_rsp_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req_ready", 32'(r_req_ready), 32'd1);
    @(posedge clk); #1;
    chk("idle_rsp_valid", 32'(r_rsp_valid), 32'd0);

    // Preload a known region of every build.
    for (int d = 0; d < 3; d++) begin
      sel = d;
      for (int w = 0; w < ((d == 0) ? 32 : 16); w++) model_txn(1'b1, 3'd2, 32'(w * 4), $urandom, 0);
    end

    sel = 0;
    foreach (tbl[i]) begin
      ref_op(0, tbl[i].we, tbl[i].f, tbl[i].addr, tbl[i].wdata, e_err, e_rd);
      txn(tbl[i].we, tbl[i].f, tbl[i].addr, tbl[i].wdata, tbl[i].hold, a_err, a_rd);
      chk($sformatf("tbl%0d_err", i), 32'(a_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_rdata", i), a_rd, tbl[i].rdata);
    end

    for (int d = 0; d < 3; d++) begin
      sel = d;
      for (int k = 0; k < 60; k++) begin
        int unsigned w;
        w = $urandom_range(0, (d == 0) ? 31 : 15);
        if ($urandom_range(0, 7) == 0) w = 32'(depth_of(d)) + $urandom_range(0, 5000);
        model_txn(1'($urandom), fsel[$urandom_range(0, 12)], (w << 2) + $urandom_range(0, 3),
                  $urandom, $urandom_range(0, 2));
      end
    end

    // Reset while waiting on a store: store must be dropped.
    sel = 0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(r_rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(r_req_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_edge_valid", 32'(r_rsp_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle", 32'(r_req_ready), 32'd1);
    model_txn(1'b0, 3'd2, 32'h20, 32'h0, 0);

    // Reset while a response is pending clears it without a clock edge.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("resp_pending", 32'(r_rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rsprst_rsp_valid", 32'(r_rsp_valid), 32'd0);
    chk("rsprst_req_ready", 32'(r_req_ready), 32'd0);
    chk("rsprst_rdata", r_rsp_rdata, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rsprst_idle_ready", 32'(r_req_ready), 32'd1);
    chk("rsprst_idle_valid", 32'(r_rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
